// File: rtl/mem_mmio_bridge_if.sv
// CPU-side request/response bus and MMIO peripheral channel for mem_mmio_bridge.
// The slave modport is the bridge view; master is the CPU/peripheral environment view.
interface mem_mmio_bridge_if #(
  parameter int DEPTH_LOG2 = 8,
  parameter int IO_ADDR_W  = 8
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [3:0]            cpu_be;
  logic [31:0]           cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_ready;
  logic                  cpu_err;
  logic [DEPTH_LOG2-1:0] dbg_addr;
  logic [31:0]           dbg_data;
  logic [IO_ADDR_W-1:0]  io_addr;
  logic [31:0]           io_dout;
  logic [3:0]            io_be;
  logic                  io_we;
  logic                  io_rd;
  logic [31:0]           io_din;
  logic                  io_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, dbg_addr, io_din, io_ack,
    output cpu_rdata, cpu_ready, cpu_err, dbg_data, io_addr, io_dout, io_be, io_we, io_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata, dbg_addr, io_din, io_ack,
    input  cpu_rdata, cpu_ready, cpu_err, dbg_data, io_addr, io_dout, io_be, io_we, io_rd
  );
endinterface

// File: rtl/mem_mmio_bridge.sv
// CPU data-side bridge: byte-strobed word RAM plus a handshaked MMIO channel, stalling via cpu_ready.
// Define MEM_BRIDGE_TIMEOUT_EN to abort MMIO accesses that see no io_ack within TIMEOUT_CYCLES.
module mem_mmio_bridge #(
  parameter int                      DEPTH_LOG2     = 8,
  parameter int                      IO_ADDR_W      = 8,
  parameter logic [31-IO_ADDR_W:0]   MMIO_BASE      = 24'h0000ff,
  parameter int                      TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_mmio_bridge_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, MEM_RD, IO_WAIT, IO_DONE} state_t;

  localparam int RAM_WORDS = 1 << DEPTH_LOG2;

  state_t                state_q;
  state_t                state_d;
  logic [31:0]           mem [RAM_WORDS];
  logic [31:0]           rdata_q;
  logic [IO_ADDR_W-1:0]  io_addr_q;
  logic [31:0]           io_dout_q;
  logic [3:0]            io_be_q;
  logic                  io_we_q;
  logic                  io_rd_q;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  is_mmio;
  logic                  cpu_ready;
  logic                  ram_wr;
  logic                  ram_rd;
  logic                  io_start;
  logic                  io_fin;
  logic                  io_abort;
  logic                  timeout;

  // High address bits beyond the RAM depth are dropped, so non-MMIO addresses alias.
  assign ram_idx = bus.cpu_addr[DEPTH_LOG2+1:2];
  assign is_mmio = (bus.cpu_addr[31:IO_ADDR_W] == MMIO_BASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cpu_ready = 1'b0;
    ram_wr    = 1'b0;
    ram_rd    = 1'b0;
    io_start  = 1'b0;
    io_fin    = 1'b0;
    io_abort  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (is_mmio) begin
            io_start = 1'b1;
            state_d  = IO_WAIT;
          end else if (bus.cpu_we) begin
            ram_wr    = 1'b1;
            cpu_ready = 1'b1;
          end else begin
            ram_rd  = 1'b1;
            state_d = MEM_RD;
          end
        end
      end
      MEM_RD: begin
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      IO_WAIT: begin
        // An ack on the terminal cycle takes priority over the timeout abort.
        if (bus.io_ack) begin
          io_fin  = 1'b1;
          state_d = IO_DONE;
        end else if (timeout) begin
          io_abort = 1'b1;
          state_d  = IO_DONE;
        end
      end
      IO_DONE: begin
        cpu_ready = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.cpu_be[b]) mem[ram_idx][8*b +: 8] <= bus.cpu_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q   <= '0;
      io_addr_q <= '0;
      io_dout_q <= '0;
      io_be_q   <= '0;
      io_we_q   <= 1'b0;
      io_rd_q   <= 1'b0;
    end else begin
      if (io_start) begin
        io_addr_q <= bus.cpu_addr[IO_ADDR_W-1:0];
        io_dout_q <= bus.cpu_wdata;
        io_be_q   <= bus.cpu_be;
        io_we_q   <= bus.cpu_we;
        io_rd_q   <= ~bus.cpu_we;
      end
      if (io_fin || io_abort) begin
        io_we_q <= 1'b0;
        io_rd_q <= 1'b0;
      end
      if (ram_rd)            rdata_q <= mem[ram_idx];
      if (io_fin && io_rd_q) rdata_q <= bus.io_din;
      if (io_abort)          rdata_q <= 32'hDEAD_BEEF;
    end
  end

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  // wait_cnt_q counts IO_WAIT cycles already spent; the last allowed one is CNT_LAST.
  assign timeout = (wait_cnt_q == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (io_start)                wait_cnt_q <= '0;
      else if (state_q == IO_WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (io_abort)                err_q <= 1'b1;
      else if (state_q == IO_DONE) err_q <= 1'b0;
    end
  end

  assign bus.cpu_err = (state_q == IO_DONE) && err_q;
`else
  assign timeout     = 1'b0;
  assign bus.cpu_err = 1'b0;
`endif

  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_rdata = rdata_q;
  assign bus.dbg_data  = mem[bus.dbg_addr];
  assign bus.io_addr   = io_addr_q;
  assign bus.io_dout   = io_dout_q;
  assign bus.io_be     = io_be_q;
  assign bus.io_we     = io_we_q;
  assign bus.io_rd     = io_rd_q;
endmodule

// File: tb/tb_mem_mmio_bridge.sv
// Directed + randomized bench for mem_mmio_bridge against a word-array/transaction reference model.
module tb_mem_mmio_bridge;
  localparam int DL = 8;
  localparam int AW = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_mmio_bridge_if #(.DEPTH_LOG2(DL), .IO_ADDR_W(AW)) bus ();

  mem_mmio_bridge #(
    .DEPTH_LOG2(DL), .IO_ADDR_W(AW), .MMIO_BASE(24'h0000ff), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] ref_mem [256];
  bit          known   [256];
  logic [31:0] exp_rdata;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ram_addr();
    logic [31:0] a;
    a = $urandom;
    if (a[31:8] == 24'h0000ff) a[31] = 1'b1;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.io_ack  = 1'b0;
  endtask

  task automatic ram_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic [7:0] i;
    i = addr[9:2];
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = addr;
    bus.cpu_wdata = data; bus.cpu_be = be; bus.dbg_addr = i; bus.io_ack = 1'b0;
    #1;
    chk("wr_ready", bus.cpu_ready, 1);
    chk("wr_err", bus.cpu_err, 0);
    chk("wr_rdata_kept", bus.cpu_rdata, exp_rdata);
    if (known[i]) chk("wr_dbg_old", bus.dbg_data, ref_mem[i]);
    ref_mem[i] = merge(known[i] ? ref_mem[i] : 32'h0, data, be);
    known[i] = known[i] | (be == 4'hf);
  endtask

  task automatic ram_read(input logic [31:0] addr, input bit stray_ack);
    logic [7:0] i;
    i = addr[9:2];
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = addr;
    bus.cpu_wdata = $urandom; bus.cpu_be = 4'($urandom);
    bus.io_ack = stray_ack; bus.io_din = $urandom;
    #1;
    chk("rd_stall", bus.cpu_ready, 0);
    @(negedge clk);
    bus.io_ack = 1'b0;
    #1;
    chk("rd_ready", bus.cpu_ready, 1);
    exp_rdata = ref_mem[i];
    chk("rd_data", bus.cpu_rdata, exp_rdata);
  endtask

  // ack asserted during the d-th IO_WAIT cycle; with ack=0 the access must time out.
  task automatic mmio(input logic [31:0] addr, input bit we, input logic [31:0] wdata,
                      input logic [3:0] be, input int d, input bit ack, input logic [31:0] din);
    int n;
    n = ack ? d : TO;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr;
    bus.cpu_wdata = wdata; bus.cpu_be = be; bus.io_ack = 1'b0;
    #1;
    chk("io_issue_stall", bus.cpu_ready, 0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bus.io_ack = ack && (k == d);
      bus.io_din = (k == d) ? din : $urandom;
      #1;
      chk("io_rd", bus.io_rd, !we);
      chk("io_we", bus.io_we, we);
      chk("io_addr", bus.io_addr, addr[7:0]);
      chk("io_dout", bus.io_dout, wdata);
      chk("io_be", bus.io_be, be);
      chk("io_wait_stall", bus.cpu_ready, 0);
    end
    @(negedge clk);
    bus.io_ack = 1'b0;
    #1;
    chk("io_done_ready", bus.cpu_ready, 1);
    chk("io_strobe_clr", {bus.io_rd, bus.io_we}, 0);
    if (!ack)    exp_rdata = 32'hDEAD_BEEF;
    else if (!we) exp_rdata = din;
    chk("io_err", bus.cpu_err, !ack);
    chk("io_rdata", bus.cpu_rdata, exp_rdata);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] w3;
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_be = 4'h0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.dbg_addr = '0; bus.io_din = '0; bus.io_ack = 1'b0;
    exp_rdata = 32'h0;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", bus.cpu_ready, 0);
    chk("rst_err", bus.cpu_err, 0);
    chk("rst_strobes", {bus.io_rd, bus.io_we}, 0);
    chk("rst_io_addr", bus.io_addr, 0);
    chk("rst_io_dout", bus.io_dout, 0);
    chk("rst_io_be", bus.io_be, 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back fill of every word: zero-latency writes with no stall.
    for (int i = 0; i < 256; i++) ram_write({22'h0, 8'(i), 2'b00}, $urandom, 4'hf);

    ram_write(32'h10, 32'h1122_3344, 4'b1111);
    ram_write(32'h10, 32'hAABB_CCDD, 4'b0010);
    ram_read(32'h10, 1'b0);
    chk("t1_read", bus.cpu_rdata, 32'h1122_CC44);
    bus.dbg_addr = 8'd4;
    #1;
    chk("t1_dbg", bus.dbg_data, 32'h1122_CC44);
    ram_read(32'h0000_0410, 1'b0);
    chk("alias_read", bus.cpu_rdata, 32'h1122_CC44);
    ram_write(32'h4, 32'hCAFE_F00D, 4'b0000);
    ram_read(32'h4, 1'b1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(1, 0) == 1) ram_write(ram_addr(), $urandom, 4'($urandom));
      else                           ram_read(ram_addr(), 1'($urandom));
    end

    mmio(32'h0000_ff08, 1'b0, 32'h0, 4'hf, 3, 1'b1, 32'h5A);
    chk("t3_rdata", bus.cpu_rdata, 32'h5A);
    chk("t3_err", bus.cpu_err, 0);

    bus.dbg_addr = 8'd3;
    #1;
    w3 = bus.dbg_data;
    chk("t4_word3_before", w3, ref_mem[3]);
    mmio(32'h0000_ff0c, 1'b1, 32'h7, 4'b0001, 2, 1'b1, 32'h0);
    bus.dbg_addr = 8'd3;
    #1;
    chk("t4_word3_after", bus.dbg_data, ref_mem[3]);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(2, 0))
        0: mmio({24'h0000ff, 8'($urandom)}, 1'($urandom), $urandom, 4'($urandom),
                $urandom_range(6, 1), 1'b1, $urandom);
        1: ram_write(ram_addr(), $urandom, 4'($urandom));
        default: ram_read(ram_addr(), 1'b0);
      endcase
    end

`ifdef MEM_BRIDGE_TIMEOUT_EN
    mmio(32'h0000_ff10, 1'b0, 32'h0, 4'hf, TO, 1'b0, 32'h0);
    chk("t5_timeout_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
    mmio(32'h0000_ff14, 1'b0, 32'h0, 4'hf, TO, 1'b1, 32'h1234_5678);
    chk("t5_lastack_err", bus.cpu_err, 0);
    mmio(32'h0000_ff18, 1'b1, 32'h55, 4'hf, TO, 1'b0, 32'h0);
    mmio(32'h0000_ff1c, 1'b0, 32'h0, 4'hf, 2, 1'b1, 32'h9);
`endif

    // Stray ack while idle must not start or complete anything.
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.io_ack  = 1'b1;
    #1;
    chk("stray_ack_ready", bus.cpu_ready, 0);
    @(negedge clk);
    bus.io_ack = 1'b0;
    #1;
    chk("stray_ack_strobes", {bus.io_rd, bus.io_we}, 0);
    ram_write(32'h20, 32'h0BAD_F00D, 4'hf);

    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_ff20;
    bus.cpu_be = 4'hf; bus.io_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_io_rd", bus.io_rd, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_io_rd", bus.io_rd, 0);
    chk("rst_mid_ready", bus.cpu_ready, 0);
    chk("rst_mid_rdata", bus.cpu_rdata, 0);
    exp_rdata = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    ram_read(32'h20, 1'b0);
    chk("post_rst_ram", bus.cpu_rdata, 32'h0BAD_F00D);
    ram_read(32'h10, 1'b0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
